// File: rtl/board_init.sv
// ---------------------------------------------------------------------------
// BoardInit: sweeps a P_PARAM_N x P_PARAM_M cell board once per rising edge
// of load, writing one cell per clock in raster order (row-major, address
// row*P_PARAM_N+col) with a pattern chosen by mode.
//
// Ports
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   load     : fill request, acted on at its rising edge only
//   mode     : fill pattern (0 clear, 1 LFSR random, 2 glider, 3 checkerboard)
//   busy     : high during every write cycle of a sweep (mirrors wr_en)
//   done     : one-cycle pulse in the cycle after the last write
//   wr_en    : cell-RAM write enable
//   wr_addr  : cell address
//   wr_data  : cell state, 1 = live
// ---------------------------------------------------------------------------
module board_init #(
    parameter int          P_PARAM_N = 400,
    parameter int          P_PARAM_M = 300,
    parameter int          P_ADDR_W  = 24,
    parameter logic [15:0] P_SEED    = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic                wr_en,
    output logic [P_ADDR_W-1:0] wr_addr,
    output logic                wr_data
);

    localparam int COL_W = (P_PARAM_N > 1) ? $clog2(P_PARAM_N) : 1;
    localparam int ROW_W = (P_PARAM_M > 1) ? $clog2(P_PARAM_M) : 1;

    localparam logic [COL_W-1:0]    LAST_COL  = COL_W'(P_PARAM_N - 1);
    localparam logic [P_ADDR_W-1:0] LAST_ADDR = P_ADDR_W'(P_PARAM_N * P_PARAM_M - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]          state_q,  state_d;
    logic                prevLoad_q;
    logic [1:0]          mode_q,   mode_d;
    logic [ROW_W-1:0]    row_q,    row_d;
    logic [COL_W-1:0]    col_q,    col_d;
    logic [15:0]         lfsr_q,   lfsr_d;
    logic                wrEn_q,   wrEn_d;
    logic [P_ADDR_W-1:0] wrAddr_q, wrAddr_d;
    logic                wrData_q, wrData_d;
    logic                done_q,   done_d;

    logic                loadRise;
    logic [ROW_W-1:0]    nextRow;
    logic [COL_W-1:0]    nextCol;

    // Fibonacci LFSR, taps 16,14,13,11: the feedback bit enters at the top
    // and bit 0 is the value shifted out to the board.
    function automatic logic [15:0] lfsrStep(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // Pattern value of one cell; rnd is the LFSR bit reserved for this write.
    function automatic logic cellValue(input logic [1:0]       m,
                                       input logic [ROW_W-1:0] r,
                                       input logic [COL_W-1:0] c,
                                       input logic             rnd);
        logic [31:0] rI;
        logic [31:0] cI;
        logic        v;
        rI = 32'(r);
        cI = 32'(c);
        case (m)
            2'd0:    v = 1'b0;
            2'd1:    v = rnd;
            2'd2:    v = ((rI == 32'd0) && (cI == 32'd1)) ||
                         ((rI == 32'd1) && (cI == 32'd2)) ||
                         ((rI == 32'd2) && (cI <= 32'd2));
            default: v = r[0] ^ c[0];
        endcase
        return v;
    endfunction

    assign loadRise = load & ~prevLoad_q;

    // Raster successor of the cell currently on the outputs.
    always_comb begin
        nextRow = row_q;
        nextCol = col_q + COL_W'(1);
        if (col_q == LAST_COL) begin
            nextCol = '0;
            nextRow = row_q + ROW_W'(1);
        end
    end

    // The row/col counters always describe the cell being presented on the
    // write port, so each edge computes the next cell's address and data
    // directly into the output registers. The write for cell 0 is therefore
    // produced on the very edge that sees the load request, and the
    // LFSR register always holds the value whose bit 0 feeds the next write.
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        row_d    = row_q;
        col_d    = col_q;
        lfsr_d   = lfsr_q;
        wrEn_d   = 1'b0;
        wrAddr_d = '0;
        wrData_d = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (loadRise) begin
                    state_d  = S_FILL;
                    mode_d   = mode;
                    row_d    = '0;
                    col_d    = '0;
                    lfsr_d   = lfsrStep(P_SEED);
                    wrEn_d   = 1'b1;
                    wrData_d = cellValue(mode, '0, '0, P_SEED[0]);
                end
            end
            S_FILL: begin
                if (wrAddr_q == LAST_ADDR) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    row_d    = nextRow;
                    col_d    = nextCol;
                    lfsr_d   = lfsrStep(lfsr_q);
                    wrEn_d   = 1'b1;
                    wrAddr_d = wrAddr_q + P_ADDR_W'(1);
                    wrData_d = cellValue(mode_q, nextRow, nextCol, lfsr_q[0]);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state, including the load edge detector, clears asynchronously so
    // a reset mid-sweep drops the write port at once and never yields done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            prevLoad_q <= 1'b0;
            mode_q     <= 2'd0;
            row_q      <= '0;
            col_q      <= '0;
            lfsr_q     <= P_SEED;
            wrEn_q     <= 1'b0;
            wrAddr_q   <= '0;
            wrData_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            prevLoad_q <= load;
            mode_q     <= mode_d;
            row_q      <= row_d;
            col_q      <= col_d;
            lfsr_q     <= lfsr_d;
            wrEn_q     <= wrEn_d;
            wrAddr_q   <= wrAddr_d;
            wrData_q   <= wrData_d;
            done_q     <= done_d;
        end
    end

    assign busy    = wrEn_q;
    assign wr_en   = wrEn_q;
    assign wr_addr = wrAddr_q;
    assign wr_data = wrData_q;
    assign done    = done_q;

endmodule

// File: tb/tb_board_init.sv
// ---------------------------------------------------------------------------
// Testbench for board_init on a 4 x 3 board. Directed scenarios: reset,
// clear, glider, checkerboard with a mid-sweep mode change, LFSR run twice,
// load held high, and reset abort followed by a restart from a held load.
// ---------------------------------------------------------------------------
module tb_board_init;

    localparam int N  = 4;
    localparam int M  = 3;
    localparam int AW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [1:0]    mode;
    logic          busy;
    logic          done;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;

    int nCompared   = 0;
    int nMismatched = 0;

    board_init #(
        .P_PARAM_N(N),
        .P_PARAM_M(M),
        .P_ADDR_W (AW),
        .P_SEED   (16'hACE1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .mode   (mode),
        .busy   (busy),
        .done   (done),
        .wr_en  (wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    // Issues a one-cycle load pulse and records one sweep, sampled on the
    // falling edge. The mode input is switched to changeMode once changeAt
    // writes have been observed (-1 never switches).
    task automatic runSweep(input  logic [1:0]  startMode,
                            input  int          changeAt,
                            input  logic [1:0]  changeMode,
                            output logic [11:0] data,
                            output int          writes,
                            output bit          firstOk,
                            output bit          orderOk,
                            output bit          doneOk,
                            output bit          idleOk);
        bit ended;
        @(negedge clk);
        mode = startMode;
        load = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        firstOk = (wr_en === 1'b1) && (wr_addr === '0);
        data    = '0;
        writes  = 0;
        orderOk = 1'b1;
        doneOk  = 1'b0;
        ended   = 1'b0;
        for (int c = 0; c < 40 && !ended; c++) begin
            if (c > 0) @(negedge clk);
            if (writes == changeAt) mode = changeMode;
            if (wr_en === 1'b1) begin
                if (wr_addr !== AW'(writes) || busy !== 1'b1 || done !== 1'b0)
                    orderOk = 1'b0;
                if (writes < 12) data[writes] = wr_data;
                writes++;
            end else begin
                ended  = 1'b1;
                doneOk = (done === 1'b1) && (busy === 1'b0) &&
                         (wr_addr === '0) && (wr_data === 1'b0);
            end
        end
        @(negedge clk);
        idleOk = (done === 1'b0) && (wr_en === 1'b0) && (busy === 1'b0);
    endtask

    task automatic test_reset();
        rst  = 1'b1;
        load = 1'b0;
        mode = 2'd0;
        repeat (2) @(negedge clk);
        nCompared++;
        if ({wr_en, busy, done, wr_data} !== 4'b0000 || wr_addr !== '0) begin
            nMismatched++;
            $display("[TB] FAIL reset_outputs: got en/busy/done/data=%b%b%b%b addr=%0d, want 0000 addr=0",
                     wr_en, busy, done, wr_data, wr_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        nCompared++;
        if (wr_en !== 1'b0 || done !== 1'b0) begin
            nMismatched++;
            $display("[TB] FAIL reset_idle: got en=%b done=%b, want 0 0", wr_en, done);
        end
    endtask

    task automatic test_clear();
        logic [11:0] d;
        int w;
        bit f, o, dn, id;
        runSweep(2'd0, -1, 2'd0, d, w, f, o, dn, id);
        nCompared++;
        if (f !== 1'b1) begin nMismatched++; $display("[TB] FAIL clear_first: got %b want 1", f); end
        nCompared++;
        if (w !== 12) begin nMismatched++; $display("[TB] FAIL clear_count: got %0d want 12", w); end
        nCompared++;
        if (o !== 1'b1) begin nMismatched++; $display("[TB] FAIL clear_order: got %b want 1", o); end
        nCompared++;
        if (d !== 12'h000) begin nMismatched++; $display("[TB] FAIL clear_data: got %h want 000", d); end
        nCompared++;
        if (dn !== 1'b1) begin nMismatched++; $display("[TB] FAIL clear_done: got %b want 1", dn); end
        nCompared++;
        if (id !== 1'b1) begin nMismatched++; $display("[TB] FAIL clear_idle: got %b want 1", id); end
    endtask

    task automatic test_glider();
        logic [11:0] d;
        int w;
        bit f, o, dn, id;
        runSweep(2'd2, -1, 2'd0, d, w, f, o, dn, id);
        nCompared++;
        if (w !== 12 || o !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL glider_sweep: got count=%0d order=%b want 12 1", w, o);
        end
        nCompared++;
        if (d !== 12'h742) begin nMismatched++; $display("[TB] FAIL glider_data: got %h want 742", d); end
        nCompared++;
        if (dn !== 1'b1 || id !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL glider_done: got done=%b idle=%b want 1 1", dn, id);
        end
    endtask

    task automatic test_checker();
        logic [11:0] d;
        int w;
        bit f, o, dn, id;
        runSweep(2'd3, 6, 2'd0, d, w, f, o, dn, id);
        nCompared++;
        if (w !== 12 || o !== 1'b1) begin
            nMismatched++;
            $display("[TB] FAIL checker_sweep: got count=%0d order=%b want 12 1", w, o);
        end
        nCompared++;
        if (d !== 12'hA5A) begin nMismatched++; $display("[TB] FAIL checker_data: got %h want a5a", d); end
        nCompared++;
        if (dn !== 1'b1) begin nMismatched++; $display("[TB] FAIL checker_done: got %b want 1", dn); end
    endtask

    // The first 12 bits shifted out of the LFSR are seed bits 0..11,
    // i.e. the low 12 bits of ACE1 in address order.
    task automatic test_lfsr();
        logic [11:0] d1;
        logic [11:0] d2;
        int w1, w2;
        bit f, o, dn, id;
        runSweep(2'd1, -1, 2'd0, d1, w1, f, o, dn, id);
        nCompared++;
        if (d1 !== 12'hCE1 || w1 !== 12) begin
            nMismatched++;
            $display("[TB] FAIL lfsr_first: got data=%h count=%0d want ce1 12", d1, w1);
        end
        runSweep(2'd1, -1, 2'd0, d2, w2, f, o, dn, id);
        nCompared++;
        if (d2 !== 12'hCE1 || w2 !== 12) begin
            nMismatched++;
            $display("[TB] FAIL lfsr_second: got data=%h count=%0d want ce1 12", d2, w2);
        end
        nCompared++;
        if (dn !== 1'b1) begin nMismatched++; $display("[TB] FAIL lfsr_done: got %b want 1", dn); end
    endtask

    task automatic test_load_held();
        int writes = 0;
        int dones  = 0;
        @(negedge clk);
        mode = 2'd0;
        load = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wr_en === 1'b1) writes++;
            if (done === 1'b1) dones++;
        end
        load = 1'b0;
        nCompared++;
        if (writes !== 12) begin nMismatched++; $display("[TB] FAIL held_writes: got %0d want 12", writes); end
        nCompared++;
        if (dones !== 1) begin nMismatched++; $display("[TB] FAIL held_done: got %0d want 1", dones); end
    endtask

    task automatic test_reset_abort();
        bit found = 1'b0;
        int dones = 0;
        int writes;
        @(negedge clk);
        mode = 2'd3;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (wr_en === 1'b1 && wr_addr === AW'(5)) found = 1'b1;
            else @(negedge clk);
        end
        nCompared++;
        if (found !== 1'b1) begin nMismatched++; $display("[TB] FAIL abort_reach5: got %b want 1", found); end
        load = 1'b1;
        #2 rst = 1'b1;
        #1;
        nCompared++;
        if ({wr_en, busy, done, wr_data} !== 4'b0000 || wr_addr !== '0) begin
            nMismatched++;
            $display("[TB] FAIL abort_async: got en/busy/done/data=%b%b%b%b addr=%0d, want 0000 addr=0",
                     wr_en, busy, done, wr_data, wr_addr);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done === 1'b1 || wr_en === 1'b1) dones++;
        end
        nCompared++;
        if (dones !== 0) begin nMismatched++; $display("[TB] FAIL abort_nodone: got %0d want 0", dones); end
        rst = 1'b0;
        @(negedge clk);
        nCompared++;
        if (wr_en !== 1'b1 || wr_addr !== '0) begin
            nMismatched++;
            $display("[TB] FAIL restart_first: got en=%b addr=%0d want 1 0", wr_en, wr_addr);
        end
        writes = (wr_en === 1'b1) ? 1 : 0;
        dones  = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wr_en === 1'b1) writes++;
            if (done === 1'b1) dones++;
        end
        load = 1'b0;
        nCompared++;
        if (writes !== 12 || dones !== 1) begin
            nMismatched++;
            $display("[TB] FAIL restart_sweep: got writes=%0d dones=%0d want 12 1", writes, dones);
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_glider();
        test_checker();
        test_lfsr();
        test_load_held();
        test_reset_abort();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
